irq_source: RTL and testbench
=============================

// Module: irq_source
// PURPOSE
//  Device-side end of the CPU interrupt handshake: turns raw pushbuttons into prioritised,
//  maskable interrupt requests for the MINT/REGFILE interrupt logic. It synchronises and
//  debounces each line, latches edges as pending, and presents one request with a code.
//  It tracks in-service lines across the CPU's acknowledge and return (eret) to support nesting.
// PARAMETERS
//  N_LINES   3      number of interrupt lines (btn width); line N_LINES-1 is highest priority
//  DB_CYCLES 20000  consecutive stable clk cycles needed to accept a new button level
//  CODE_W    2      width of code; code = line index + 1, 0 = no request
// PORTS
//  clk         in   1        system clock; all state on rising edge
//  in_RST      in   1        asynchronous, active-high reset
//  btn         in   N_LINES  raw asynchronous pushbutton levels (pro_reset)
//  ie          in   1        CPU global interrupt enable
//  inm         in   N_LINES  per-line mask, 1 = masked
//  ack         in   1        1-cycle pulse: CPU has taken the request currently on code
//  eret        in   1        1-cycle pulse: CPU returned from the innermost handler
//  req         out  1        interrupt request to CPU
//  code        out  CODE_W   requested line + 1, held stable while req=1; 0 when req=0
//  in_service  out  N_LINES  lines whose handlers are active (nested)
//  pending     out  N_LINES  latched, not-yet-acknowledged edges (drives leds)
// BEHAVIOUR
//  - Reset (async, in_RST=1): sync FFs, debounced levels, counters, pending, in_service = 0;
//    state=IDLE; req=0, code=0. Deasserting in_RST does not create an edge on held buttons.
//  - Input path per line: 2-FF synchroniser -> debounce counter. The counter clears whenever
//    the synced level equals the accepted level or changes. When the level differs for
//    DB_CYCLES consecutive cycles, the new level is accepted. A press is accepted
//    DB_CYCLES+2 cycles after the btn edge, with glitches <DB_CYCLES ignored.
//  - A rising edge of an accepted level sets pending[i] on the next cycle. Falling edges do
//    nothing. Repeated edges while pending collapse into one.
//  - Eligible line i: pending[i] & ~inm[i] & ie & (i > highest set bit of in_service,
//    or in_service==0). Winner = highest eligible index.
//  - FSM IDLE: if any eligible line, latch winner into code_r and go to REQ on the next cycle
//    (req rises 1 cycle after eligibility).
//  - FSM REQ: req=1, code=code_r+1 frozen (a higher line arriving does not change code).
//      ack=1  -> clear pending[code_r], set in_service[code_r], go to IDLE (req=0 next cycle).
//      line code_r no longer eligible (ie=0 or masked) and ack=0 -> withdraw: go to IDLE,
//        pending kept.
//  - eret=1 (any state): clear the highest set bit of in_service. Ignored if in_service==0.
//  - ack in IDLE: ignored. ack and eret in the same cycle: apply eret first (clear top), then
//    set the acked bit.
//  - New accepted edge on line k in the same cycle as ack of k: pending[k] stays 1 (the new
//    edge wins).
//  - Counter widths are $clog2(DB_CYCLES+1). The counter saturates and never wraps.
// STRUCTURE
//  - Shared package irq_pkg: CODE_NONE=0, FSM state encoding {IDLE,REQ}, default N_LINES/CODE_W.
//  - One sub-module, irq_debounce (sync + counter + accepted level + rise pulse), instantiated
//    N_LINES times via generate. Priority encode, pending/in_service and FSM live in irq_source.
// TESTING (bench uses DB_CYCLES=4)
//  1 btn[0] 0->1 held; ie=1, inm=0 -> pending[0]=1 at cycle 7, req=1/code=1 at cycle 8;
//    ack pulse -> req=0, in_service=001, pending=000.
//  2 btn[1] pulses high 3 cycles -> no pending, req stays 0 (glitch rejected).
//  3 btn[0] and btn[2] accepted same cycle -> code=3 first; ack; btn[1] edge -> no req
//    (1<2). eret -> in_service=001; code=2 raised; ack -> in_service=011.
//  4 In REQ code=2, drop ie for 1 cycle -> req=0 next cycle, pending[1] kept. ie=1 -> req=1,
//    code=2 again.
//  5 inm=001 with pending[0]=1 -> req=0. Clear inm -> req=1, code=1.
//  6 in_RST pulse mid-REQ with btn[2] held -> req=0, code=0, pending=0; after release no
//    request until btn[2] is released and pressed again.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the pushbutton interrupt source: default sizes,
// the "no request" code and the request FSM state encoding.
package irq_pkg;

    localparam int N_LINES_DEF   = 3;
    localparam int CODE_W_DEF    = 2;
    localparam int DB_CYCLES_DEF = 20000;
    localparam int CODE_NONE     = 0;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_debounce.sv
// One interrupt line front end: 2-FF synchroniser, saturating debounce
// counter, accepted level and a one-cycle pulse on an accepted rising edge.
module irq_debounce #(
    parameter int DB_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       vld_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            vld_q   <= 2'b00;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            vld_q   <= {vld_q[0], 1'b1};
            level_q <= level_d;
            prev_q  <= level_q;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A button held through reset must be seen released once (with a filled
    // synchroniser) before its next press can raise an edge.
    assign armed_d = armed_q | (vld_q[1] & ~sync2_q);
    assign rise_o  = level_q & ~prev_q & armed_q;

endmodule

// File: rtl/irq_source.sv
// Prioritised, maskable interrupt requester with nested in-service tracking
// across CPU acknowledge and eret.
module irq_source
    import irq_pkg::*;
#(
    parameter int N_LINES   = N_LINES_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CODE_W    = CODE_W_DEF
) (
    input  logic               clk,
    input  logic               in_RST,
    input  logic [N_LINES-1:0] btn,
    input  logic               ie,
    input  logic [N_LINES-1:0] inm,
    input  logic               ack,
    input  logic               eret,
    output logic               req,
    output logic [CODE_W-1:0]  code,
    output logic [N_LINES-1:0] in_service,
    output logic [N_LINES-1:0] pending,
    output irq_state_e         state_dbg
);

    localparam int IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;

    logic [N_LINES-1:0] rise;

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        irq_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .rst    (in_RST),
            .btn_i  (btn[g]),
            .rise_o (rise[g])
        );
    end

    irq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   code_q, code_d;
    logic [N_LINES-1:0] pend_q, pend_d;
    logic [N_LINES-1:0] isv_q, isv_d;
    logic [N_LINES-1:0] eligible;
    logic [N_LINES-1:0] top_mask;
    logic [IDX_W-1:0]   winner;
    logic               any_elig;

    always_ff @(posedge clk or posedge in_RST) begin
        if (in_RST) begin
            state_q <= IDLE;
            code_q  <= '0;
            pend_q  <= '0;
            isv_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            isv_q   <= isv_d;
        end
    end

    // A line may interrupt only above every handler already in service.
    always_comb begin
        eligible = '0;
        winner   = '0;
        any_elig = 1'b0;
        top_mask = '0;
        for (int i = 0; i < N_LINES; i++) begin
            eligible[i] = pend_q[i] & ~inm[i] & ie & ((isv_q >> i) == '0);
            if (eligible[i]) begin
                winner   = IDX_W'(i);
                any_elig = 1'b1;
            end
            if (isv_q[i]) begin
                top_mask    = '0;
                top_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pend_d  = pend_q;
        isv_d   = isv_q;
        // eret lands before the ack sets its bit, so both can share a cycle.
        if (eret) begin
            isv_d = isv_q & ~top_mask;
        end
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    code_d  = winner;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    pend_d[code_q] = 1'b0;
                    isv_d[code_q]  = 1'b1;
                    state_d        = IDLE;
                end else if (!eligible[code_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = pend_d | rise;
    end

    assign req        = (state_q == REQ);
    assign code       = req ? (CODE_W'(code_q) + CODE_W'(1)) : CODE_W'(CODE_NONE);
    assign in_service = isv_q;
    assign pending    = pend_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_irq_source.sv
// Vector-table bench for irq_source with a short debounce window; expected
// outputs travel through a queue from the driving step to the sampling step.
module tb_irq_source;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       in_RST;
    logic [2:0] btn;
    logic       ie;
    logic [2:0] inm;
    logic       ack;
    logic       eret;
    logic       req;
    logic [1:0] code;
    logic [2:0] in_service;
    logic [2:0] pending;
    irq_state_e state_dbg;

    irq_source #(.N_LINES(3), .DB_CYCLES(4), .CODE_W(2)) dut (
        .clk        (clk),
        .in_RST     (in_RST),
        .btn        (btn),
        .ie         (ie),
        .inm        (inm),
        .ack        (ack),
        .eret       (eret),
        .req        (req),
        .code       (code),
        .in_service (in_service),
        .pending    (pending),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] btn;
        logic       ie;
        logic [2:0] inm;
        logic       ack;
        logic       eret;
        int         n;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    function automatic void add(input logic [2:0] b, input logic e, input logic [2:0] m,
                                input logic a, input logic r, input int n,
                                input logic x_req, input logic [1:0] x_code,
                                input logic [2:0] x_isv, input logic [2:0] x_pend);
        vec_t v;
        v.btn  = b;
        v.ie   = e;
        v.inm  = m;
        v.ack  = a;
        v.eret = r;
        v.n    = n;
        v.exp  = {x_req, x_code, x_isv, x_pend};
        vecs.push_back(v);
    endfunction

    task automatic check_field(input string name, input int idx,
                               input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic compare_out(input string tag, input int idx);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s step %0d: got empty queue expected entry", tag, idx);
        end else begin
            e = exp_q.pop_front();
            check_field({tag, ".req"},     idx, {3'b0, req},        {3'b0, e[8]});
            check_field({tag, ".code"},    idx, {2'b0, code},       {2'b0, e[7:6]});
            check_field({tag, ".in_svc"},  idx, {1'b0, in_service}, {1'b0, e[5:3]});
            check_field({tag, ".pending"}, idx, {1'b0, pending},    {1'b0, e[2:0]});
        end
    endtask

    task automatic run_table(input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            exp_q.push_back(vecs[k].exp);
            for (int c = 0; c < vecs[k].n; c++) begin
                btn  = vecs[k].btn;
                ie   = vecs[k].ie;
                inm  = vecs[k].inm;
                ack  = (c == 0) ? vecs[k].ack : 1'b0;
                eret = (c == 0) ? vecs[k].eret : 1'b0;
                @(posedge clk);
                #1;
            end
            ack  = 1'b0;
            eret = 1'b0;
            compare_out(tag, k);
        end
        vecs.delete();
    endtask

    initial begin
        btn    = 3'b000;
        ie     = 1'b1;
        inm    = 3'b000;
        ack    = 1'b0;
        eret   = 1'b0;
        in_RST = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(9'b0);
        compare_out("reset", 0);
        check_field("reset.state", 0, {3'b0, state_dbg}, {3'b0, IDLE});
        @(negedge clk);
        in_RST = 1'b0;

        //    btn    ie   inm    ack   eret  n   req  code   isv     pend
        add(3'b000, 1, 3'b000, 0, 0, 5,  0, 2'd0, 3'b000, 3'b000);
        // single press: pending after 7 edges, request after 8, then ack
        add(3'b001, 1, 3'b000, 0, 0, 6,  0, 2'd0, 3'b000, 3'b000);
        add(3'b001, 1, 3'b000, 0, 0, 1,  0, 2'd0, 3'b000, 3'b001);
        add(3'b001, 1, 3'b000, 0, 0, 1,  1, 2'd1, 3'b000, 3'b001);
        add(3'b001, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b001, 3'b000);
        // 3-cycle glitch on line 1 is rejected; then release line 0
        add(3'b011, 1, 3'b000, 0, 0, 3,  0, 2'd0, 3'b001, 3'b000);
        add(3'b001, 1, 3'b000, 0, 0, 8,  0, 2'd0, 3'b001, 3'b000);
        add(3'b000, 1, 3'b000, 0, 0, 8,  0, 2'd0, 3'b001, 3'b000);
        // lines 0 and 2 together: 2 wins, 1 blocked under 2, eret lets 1 through
        add(3'b101, 1, 3'b000, 0, 0, 7,  0, 2'd0, 3'b001, 3'b101);
        add(3'b101, 1, 3'b000, 0, 0, 1,  1, 2'd3, 3'b001, 3'b101);
        add(3'b101, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b101, 3'b001);
        add(3'b111, 1, 3'b000, 0, 0, 7,  0, 2'd0, 3'b101, 3'b011);
        add(3'b111, 1, 3'b000, 0, 0, 1,  0, 2'd0, 3'b101, 3'b011);
        add(3'b111, 1, 3'b000, 0, 1, 1,  0, 2'd0, 3'b001, 3'b011);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd2, 3'b001, 3'b011);
        add(3'b111, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b011, 3'b001);
        // re-arm line 1 and unwind both handlers
        add(3'b101, 1, 3'b000, 0, 0, 8,  0, 2'd0, 3'b011, 3'b001);
        add(3'b111, 1, 3'b000, 0, 0, 7,  0, 2'd0, 3'b011, 3'b011);
        add(3'b111, 1, 3'b000, 0, 1, 1,  0, 2'd0, 3'b001, 3'b011);
        add(3'b111, 1, 3'b000, 0, 1, 1,  1, 2'd2, 3'b000, 3'b011);
        // ie dropped for one cycle withdraws, restored re-requests same code
        add(3'b111, 0, 3'b000, 0, 0, 1,  0, 2'd0, 3'b000, 3'b011);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd2, 3'b000, 3'b011);
        // higher line pending while in REQ does not change the frozen code
        add(3'b011, 1, 3'b000, 0, 0, 8,  1, 2'd2, 3'b000, 3'b011);
        add(3'b111, 1, 3'b000, 0, 0, 7,  1, 2'd2, 3'b000, 3'b111);
        add(3'b111, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b010, 3'b101);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd3, 3'b010, 3'b101);
        // ack and eret together: top bit cleared before acked bit set
        add(3'b111, 1, 3'b000, 1, 1, 1,  0, 2'd0, 3'b100, 3'b001);
        // mask line 0 while pending, then unmask
        add(3'b111, 1, 3'b001, 0, 1, 1,  0, 2'd0, 3'b000, 3'b001);
        add(3'b111, 1, 3'b001, 0, 0, 3,  0, 2'd0, 3'b000, 3'b001);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd1, 3'b000, 3'b001);
        add(3'b111, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b001, 3'b000);
        // ack while idle changes nothing
        add(3'b111, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b001, 3'b000);
        // bring line 2 into REQ ahead of the reset pulse
        add(3'b011, 1, 3'b000, 0, 0, 8,  0, 2'd0, 3'b001, 3'b000);
        add(3'b111, 1, 3'b000, 0, 0, 7,  0, 2'd0, 3'b001, 3'b100);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd3, 3'b001, 3'b100);
        run_table("seq_a");

        // asynchronous reset in the middle of a request with buttons held
        #2;
        in_RST = 1'b1;
        #1;
        exp_q.push_back(9'b0);
        compare_out("mid_reset", 0);
        check_field("mid_reset.state", 0, {3'b0, state_dbg}, {3'b0, IDLE});
        @(negedge clk);
        in_RST = 1'b0;

        // held buttons stay silent until released and pressed again
        add(3'b111, 1, 3'b000, 0, 0, 20, 0, 2'd0, 3'b000, 3'b000);
        add(3'b011, 1, 3'b000, 0, 0, 8,  0, 2'd0, 3'b000, 3'b000);
        add(3'b111, 1, 3'b000, 0, 0, 7,  0, 2'd0, 3'b000, 3'b100);
        add(3'b111, 1, 3'b000, 0, 0, 1,  1, 2'd3, 3'b000, 3'b100);
        add(3'b111, 1, 3'b000, 1, 0, 1,  0, 2'd0, 3'b100, 3'b000);
        run_table("seq_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
